lane_seq_checker: RTL and testbench
===================================

# lane_seq_checker

Receive-side checker for the N-lane `a_if` interface array. It sits at the sink end of a lane bundle driven by a lane source, and each enabled cycle it samples every lane's `long_name` bit into an N-bit word. It locks onto an incrementing-counter pattern, then checks that each later sample equals the previous sample plus one, modulo 2^N. It reports lock status, a saturating mismatch count and a pulse on each counter wrap, so that lane integrity can be checked in-system instead of only in the bench.

## Interface
- `N`, 4: number of lanes; the word width is N bits.
- `LOCK_LEN`, 2: number of consecutive correct increments required to enter LOCKED; must be at least 1.
- `ERR_W`, 8: width of the error counter.
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous reset, active high.
- `i_intf_sink`  in  `a_if.sink [N-1:0]`  lane array; lane i supplies bit i of the sample.
- `en`  in  1  sample enable; when low, all state holds.
- `clear`  in  1  synchronous clear: returns to IDLE and zeroes `err_cnt`.
- `data_out`  out  N  last sampled word, registered.
- `locked`  out  1  high while the state is LOCKED.
- `err_cnt`  out  ERR_W  number of mismatches seen in LOCKED; saturates at all-ones.
- `wrap_pulse`  out  1  one-cycle pulse after an all-ones sample is accepted in LOCKED.

## Operation
- sample = {lane N-1 … lane 0} `long_name`, read combinationally and acted on at the clock edge when `en`=1.
- IDLE, `en`=1: set `exp` to sample+1 and `match_cnt` to 0, then go to SYNC.
- SYNC, `en`=1:
  - sample == `exp`: increment `exp` and `match_cnt`; when the new `match_cnt` equals LOCK_LEN, go to LOCKED.
  - mismatch: reseed `exp` to sample+1 and `match_cnt` to 0, stay in SYNC; `err_cnt` is not incremented.
- LOCKED, `en`=1:
  - sample == `exp`: increment `exp`; if the sample is all-ones, set `wrap_pulse` to 1 for the next cycle.
  - mismatch: increment `err_cnt` (saturating), reseed `exp` to sample+1 and `match_cnt` to 0, go to SYNC.
- `exp` arithmetic is N bits and wraps: all-ones + 1 = 0. `match_cnt` is wide enough to hold LOCK_LEN.
- `data_out` loads the sample on every `en`=1 edge, regardless of state.
- `en`=0: state, `exp`, `match_cnt`, `data_out` and `err_cnt` hold; `wrap_pulse` is 0.
- `clear`=1 takes priority over everything except `rst`. At that edge: go to IDLE, `err_cnt` = 0, `match_cnt` = 0, `wrap_pulse` = 0, and `data_out` still loads if `en`=1.
- A mismatch in the same cycle as `clear`: clear wins and the mismatch is not counted.

## Timing
- Reset values: `data_out`=0, `locked`=0, `err_cnt`=0, `wrap_pulse`=0; internally state=IDLE, `exp`=0, `match_cnt`=0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge. The first enabled edge after reset release is treated as IDLE.
- All outputs are registered. Every response appears after the edge that sampled the stimulus, i.e. 1-cycle latency.
- Minimum lock time: 1 + LOCK_LEN enabled edges from IDLE.
- `locked` is the registered state decode. It falls at the same edge that counts a mismatch.

## Structure
- Package `lane_chk_pkg`: the state enum `lane_chk_state_e` {IDLE, SYNC, LOCKED} and the default lane-count constant `N`.
- Sub-module `lane_gather`: a generate loop that flattens the `a_if.sink` array into the N-bit sample vector. This keeps interface-array indexing out of the FSM.
- The top level holds the FSM, `exp`, `match_cnt`, `err_cnt`, `wrap_pulse` and `data_out` registers.

## Test plan
- N=4, LOCK_LEN=2, `en`=1, lanes driven 0,1,2,…: `locked` rises after the third edge (sample 2); `err_cnt` stays 0.
- Continue counting 3…15, 0, 1: `wrap_pulse`=1 for exactly the one cycle after sample 15 is accepted; sample 0 matches; `locked` stays high.
- While locked, drive 5,6,9,10,11: `err_cnt`=1 and `locked`=0 after the edge sampling 9; `locked`=1 again after the edge sampling 11.
- Locked at 3, hold `en`=0 for 4 cycles while the lanes show garbage, then `en`=1 with 4: no error, `data_out` stays 3 during the gap, `locked` stays high.
- ERR_W=2, LOCK_LEN=1: force five lock/mismatch cycles; `err_cnt` saturates at 3. Then pulse `clear` in the same cycle as a mismatch: `err_cnt`=0 and state is IDLE.
- Assert `rst` between clock edges while locked with `err_cnt`=2: all outputs read 0 before the next edge, and relock from the new data works after release.

Source files
------------

// File: rtl/lane_chk_pkg.sv
// Shared types and defaults for the lane sequence checker.
package lane_chk_pkg;
  localparam int N = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lane_chk_state_e;
endpackage

// File: rtl/a_if.sv
// Single-bit lane interface; the source drives long_name, the sink reads it.
interface a_if;
  logic long_name;

  modport source (output long_name);
  modport sink   (input  long_name);
endinterface

// File: rtl/lane_gather.sv
// Flattens an array of a_if sinks into one word; lane i lands on bit i.
module lane_gather #(
  parameter int N = 4
) (
  a_if.sink          lanes [N-1:0],
  output logic [N-1:0] sample
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign sample[i] = lanes[i].long_name;
  end
endmodule

// File: rtl/lane_seq_checker.sv
// Locks onto an incrementing counter carried across N lanes, then counts
// increment violations and flags each wrap through all-ones.
module lane_seq_checker #(
  parameter int N        = lane_chk_pkg::N,
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  a_if.sink                i_intf_sink [N-1:0],
  input  logic             en,
  input  logic             clear,
  output logic [N-1:0]     data_out,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse,
  output logic [1:0]       state_dbg
);
  import lane_chk_pkg::*;

  localparam int MC_W = $clog2(LOCK_LEN + 1);

  lane_chk_state_e state, state_n;
  logic [N-1:0]     sample;
  logic [N-1:0]     exp_q, exp_n;
  logic [MC_W-1:0]  match_cnt, match_cnt_n;
  logic [ERR_W-1:0] err_cnt_n;
  logic             wrap_n;
  logic [N-1:0]     data_n;

  lane_gather #(.N(N)) u_gather (
    .lanes  (i_intf_sink),
    .sample (sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      exp_q      <= '0;
      match_cnt  <= '0;
      err_cnt    <= '0;
      wrap_pulse <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_n;
      exp_q      <= exp_n;
      match_cnt  <= match_cnt_n;
      err_cnt    <= err_cnt_n;
      wrap_pulse <= wrap_n;
      data_out   <= data_n;
    end
  end

  always_comb begin
    state_n     = state;
    exp_n       = exp_q;
    match_cnt_n = match_cnt;
    err_cnt_n   = err_cnt;
    wrap_n      = 1'b0;
    data_n      = data_out;
    if (en) begin
      data_n = sample;
      case (state)
        IDLE: begin
          exp_n       = sample + N'(1);
          match_cnt_n = '0;
          state_n     = SYNC;
        end
        SYNC: begin
          if (sample == exp_q) begin
            exp_n       = exp_q + N'(1);
            match_cnt_n = match_cnt + MC_W'(1);
            if (match_cnt_n == MC_W'(LOCK_LEN)) state_n = LOCKED;
          end else begin
            exp_n       = sample + N'(1);
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (sample == exp_q) begin
            exp_n  = exp_q + N'(1);
            wrap_n = &sample;
          end else begin
            if (err_cnt != '1) err_cnt_n = err_cnt + ERR_W'(1);
            exp_n       = sample + N'(1);
            match_cnt_n = '0;
            state_n     = SYNC;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Clear overrides any mismatch accounting done above in the same cycle.
    if (clear) begin
      state_n     = IDLE;
      err_cnt_n   = '0;
      match_cnt_n = '0;
      wrap_n      = 1'b0;
    end
  end

  assign locked    = (state == LOCKED);
  assign state_dbg = state;
endmodule

// File: tb/tb_lane_seq_checker.sv
// Directed bench for lane_seq_checker: lock, wrap, resync, enable gaps,
// saturation with clear, and asynchronous reset.
module tb_lane_seq_checker;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b, clear_a, clear_b;
  logic [N-1:0] lane_val;

  logic [N-1:0] data_a, data_b;
  logic         locked_a, locked_b, wrap_a, wrap_b;
  logic [7:0]   err_a;
  logic [1:0]   err_b;
  logic [1:0]   st_a, st_b;

  int checks   = 0;
  int failures = 0;

  a_if lanes [N-1:0] ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign lanes[g].long_name = lane_val[g];
  end

  always #5 clk = ~clk;

  lane_seq_checker #(.N(N), .LOCK_LEN(2), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .i_intf_sink(lanes), .en(en_a), .clear(clear_a),
    .data_out(data_a), .locked(locked_a), .err_cnt(err_a),
    .wrap_pulse(wrap_a), .state_dbg(st_a)
  );

  lane_seq_checker #(.N(N), .LOCK_LEN(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .i_intf_sink(lanes), .en(en_b), .clear(clear_b),
    .data_out(data_b), .locked(locked_b), .err_cnt(err_b),
    .wrap_pulse(wrap_b), .state_dbg(st_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present inputs, take one rising edge, then settle just past it.
  task automatic step(input logic [N-1:0] v, input logic ea, input logic eb);
    lane_val = v;
    en_a     = ea;
    en_b     = eb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [N-1:0] d, input logic l,
                         input logic [7:0] e, input logic w);
    check({tag, "_data"},   32'(data_a),   32'(d));
    check({tag, "_locked"}, 32'(locked_a), 32'(l));
    check({tag, "_err"},    32'(err_a),    32'(e));
    check({tag, "_wrap"},   32'(wrap_a),   32'(w));
  endtask

  logic [N-1:0] garbage [4];

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    lane_val = '0;
    garbage[0] = 4'd9; garbage[1] = 4'd0; garbage[2] = 4'd7; garbage[3] = 4'd13;
    @(posedge clk); @(posedge clk); #1;
    check_a("reset", 4'd0, 1'b0, 8'd0, 1'b0);
    check("reset_state", 32'(st_a), 32'd0);
    rst = 1'b0;

    // Lock on 0,1,2: locked only after the third edge.
    step(4'd0, 1'b1, 1'b0); check_a("lock0", 4'd0, 1'b0, 8'd0, 1'b0);
    check("lock0_state", 32'(st_a), 32'd1);
    step(4'd1, 1'b1, 1'b0); check_a("lock1", 4'd1, 1'b0, 8'd0, 1'b0);
    step(4'd2, 1'b1, 1'b0); check_a("lock2", 4'd2, 1'b1, 8'd0, 1'b0);

    // Count through the wrap; wrap_pulse only after sample 15.
    for (int v = 3; v <= 15; v++) begin
      step(4'(v), 1'b1, 1'b0);
      check_a("count", 4'(v), 1'b1, 8'd0, (v == 15));
    end
    step(4'd0, 1'b1, 1'b0); check_a("wrap0", 4'd0, 1'b1, 8'd0, 1'b0);
    step(4'd1, 1'b1, 1'b0); check_a("wrap1", 4'd1, 1'b1, 8'd0, 1'b0);

    // Mismatch at 9 drops lock and counts; relock after 10, 11.
    for (int v = 2; v <= 6; v++) step(4'(v), 1'b1, 1'b0);
    check_a("pre_mis", 4'd6, 1'b1, 8'd0, 1'b0);
    step(4'd9,  1'b1, 1'b0); check_a("mis9",  4'd9,  1'b0, 8'd1, 1'b0);
    step(4'd10, 1'b1, 1'b0); check_a("mis10", 4'd10, 1'b0, 8'd1, 1'b0);
    step(4'd11, 1'b1, 1'b0); check_a("mis11", 4'd11, 1'b1, 8'd1, 1'b0);

    // Count to 3 (through another wrap), then an enable gap with garbage.
    for (int v = 12; v <= 19; v++) step(4'(v), 1'b1, 1'b0);
    check_a("at3", 4'd3, 1'b1, 8'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(garbage[k], 1'b0, 1'b0);
      check_a("gap", 4'd3, 1'b1, 8'd1, 1'b0);
    end
    step(4'd4, 1'b1, 1'b0); check_a("after_gap", 4'd4, 1'b1, 8'd1, 1'b0);

    // Second error, relock, then asynchronous reset between edges.
    step(4'd8,  1'b1, 1'b0); check_a("mis8", 4'd8, 1'b0, 8'd2, 1'b0);
    step(4'd9,  1'b1, 1'b0);
    step(4'd10, 1'b1, 1'b0); check_a("relock", 4'd10, 1'b1, 8'd2, 1'b0);
    #2 rst = 1'b1;
    #1 check_a("async_rst", 4'd0, 1'b0, 8'd0, 1'b0);
    check("async_rst_state", 32'(st_a), 32'd0);
    #1 rst = 1'b0;
    step(4'd7, 1'b1, 1'b0); check_a("post0", 4'd7, 1'b0, 8'd0, 1'b0);
    step(4'd8, 1'b1, 1'b0); check_a("post1", 4'd8, 1'b0, 8'd0, 1'b0);
    step(4'd9, 1'b1, 1'b0); check_a("post2", 4'd9, 1'b1, 8'd0, 1'b0);

    // LOCK_LEN=1, ERR_W=2: five mismatches saturate at 3.
    step(4'd0, 1'b0, 1'b1);
    step(4'd1, 1'b0, 1'b1); check("b_lock", 32'(locked_b), 32'd1);
    step(4'd5,  1'b0, 1'b1); check("b_err1", 32'(err_b), 32'd1);
    check("b_err1_locked", 32'(locked_b), 32'd0);
    step(4'd6,  1'b0, 1'b1); check("b_relock1", 32'(locked_b), 32'd1);
    step(4'd0,  1'b0, 1'b1); check("b_err2", 32'(err_b), 32'd2);
    step(4'd1,  1'b0, 1'b1);
    step(4'd9,  1'b0, 1'b1); check("b_err3", 32'(err_b), 32'd3);
    step(4'd10, 1'b0, 1'b1);
    step(4'd3,  1'b0, 1'b1); check("b_err4_sat", 32'(err_b), 32'd3);
    step(4'd4,  1'b0, 1'b1); check("b_relock4", 32'(locked_b), 32'd1);
    step(4'd12, 1'b0, 1'b1); check("b_err5_sat", 32'(err_b), 32'd3);
    step(4'd13, 1'b0, 1'b1); check("b_relock5", 32'(locked_b), 32'd1);

    // Clear coincident with a mismatch: nothing counted, back to IDLE.
    clear_b = 1'b1;
    step(4'd7, 1'b0, 1'b1);
    clear_b = 1'b0;
    check("b_clr_err",    32'(err_b),    32'd0);
    check("b_clr_state",  32'(st_b),     32'd0);
    check("b_clr_locked", 32'(locked_b), 32'd0);
    check("b_clr_data",   32'(data_b),   32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
